// File: rtl/lcd1602_responder.sv
// HD44780-compatible responder for the 1602 LCD bus: decodes driver strobes, keeps a
// 2x16 DDRAM image with address counter, enforces busy timing and exposes a read port.
module lcd1602_responder #(
  parameter int unsigned BUSY_SHORT = 50,
  parameter int unsigned BUSY_LONG  = 2000
) (
  input  logic       CLK,
  input  logic       RST_n,
  input  logic       LCD_EN,
  input  logic       LCD_RS,
  input  logic       LCD_RW,
  input  logic [7:0] LCD_Data,
  input  logic [4:0] RD_Addr,
  output logic [7:0] RD_Char,
  output logic       Busy,
  output logic       Disp_On,
  output logic [2:0] Func_Bits,
  output logic       Wr_Strobe,
  output logic [4:0] Wr_Index,
  output logic       Proto_Err,
  output logic [7:0] Viol_Cnt
);

  localparam int unsigned BUSY_MAX = (BUSY_LONG > BUSY_SHORT) ? BUSY_LONG : BUSY_SHORT;
  localparam int unsigned CNT_W    = $clog2(BUSY_MAX + 1);
  localparam int unsigned DEPTH    = 32;
  localparam logic [7:0]  SPACE    = 8'h20;

  typedef enum logic [0:0] {ST_IDLE, ST_FILL} fill_state_t;

  logic             en_d;
  logic [6:0]       ac;
  logic             inc_mode;
  logic             cg_mode;
  fill_state_t      fill_state;
  logic [4:0]       fill_idx;
  logic [CNT_W-1:0] busy_cnt;
  logic [7:0]       ddram [DEPTH];

  logic       strobe_c;
  logic       accept_c;
  logic       cmd_c;
  logic       long_c;
  logic       store_c;
  logic [4:0] ac_idx_c;

  // Address counter step with the two-line wrap of the 1602 DDRAM map.
  function automatic logic [6:0] ac_step(input logic [6:0] a, input logic up);
    logic [6:0] r;
    if (up) begin
      if (a == 7'h27)      r = 7'h40;
      else if (a == 7'h67) r = 7'h00;
      else                 r = a + 7'd1;
    end else begin
      if (a == 7'h00)      r = 7'h67;
      else if (a == 7'h40) r = 7'h27;
      else                 r = a - 7'd1;
    end
    return r;
  endfunction

  assign strobe_c = en_d & ~LCD_EN;
  assign accept_c = strobe_c & ~Busy & ~LCD_RW;
  assign cmd_c    = accept_c & ~LCD_RS;
  assign long_c   = cmd_c & (LCD_Data[7:2] == 6'd0) & (LCD_Data[1:0] != 2'd0);
  assign ac_idx_c = {ac[6], ac[3:0]};
  // Only the visible 16 columns of each line (0x00-0x0F, 0x40-0x4F) are backed by storage.
  assign store_c  = accept_c & LCD_RS & ~cg_mode & (ac[5:4] == 2'b00);

  // Strobe decode, command/data state and the clear-fill sequencer.
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      en_d       <= 1'b0;
      ac         <= 7'd0;
      inc_mode   <= 1'b1;
      cg_mode    <= 1'b0;
      Disp_On    <= 1'b0;
      Func_Bits  <= 3'd0;
      Wr_Strobe  <= 1'b0;
      Wr_Index   <= 5'd0;
      Proto_Err  <= 1'b0;
      Viol_Cnt   <= 8'd0;
      fill_state <= ST_IDLE;
      fill_idx   <= 5'd0;
    end else begin
      en_d      <= LCD_EN;
      Wr_Strobe <= 1'b0;

      case (fill_state)
        ST_FILL: begin
          fill_idx <= fill_idx + 5'd1;
          if (fill_idx == 5'd31) fill_state <= ST_IDLE;
        end
        default: fill_state <= ST_IDLE;
      endcase

      if (strobe_c && Busy) begin
        if (Viol_Cnt != 8'hFF) Viol_Cnt <= Viol_Cnt + 8'd1;
      end else if (strobe_c && LCD_RW) begin
        Proto_Err <= 1'b1;
      end else if (cmd_c) begin
        casez (LCD_Data)
          8'b1???????: begin
            ac      <= LCD_Data[6:0];
            cg_mode <= 1'b0;
          end
          8'b01??????: cg_mode   <= 1'b1;
          8'b001?????: Func_Bits <= LCD_Data[4:2];
          8'b0001????: if (!LCD_Data[3]) ac <= ac_step(ac, LCD_Data[2]);
          8'b00001???: Disp_On   <= LCD_Data[2];
          8'b000001??: inc_mode  <= LCD_Data[1];
          8'b0000001?: ac        <= 7'd0;
          8'b00000001: begin
            ac         <= 7'd0;
            inc_mode   <= 1'b1;
            fill_state <= ST_FILL;
            fill_idx   <= 5'd0;
          end
          default: ;
        endcase
      end else if (accept_c && !cg_mode) begin
        ac <= ac_step(ac, inc_mode);
        if (store_c) begin
          Wr_Strobe <= 1'b1;
          Wr_Index  <= ac_idx_c;
        end
      end
    end
  end

  // Busy window: high for exactly the loaded number of cycles, starting with the update cycle.
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      busy_cnt <= '0;
      Busy     <= 1'b0;
    end else if (accept_c) begin
      busy_cnt <= long_c ? CNT_W'(BUSY_LONG - 1) : CNT_W'(BUSY_SHORT - 1);
      Busy     <= 1'b1;
    end else if (busy_cnt != '0) begin
      busy_cnt <= busy_cnt - CNT_W'(1);
    end else begin
      Busy <= 1'b0;
    end
  end

  // DDRAM image: clear fill has priority; data writes cannot overlap it because Busy covers the fill.
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      for (int i = 0; i < DEPTH; i++) ddram[i] <= SPACE;
    end else if (fill_state == ST_FILL) begin
      ddram[fill_idx] <= SPACE;
    end else if (store_c) begin
      ddram[ac_idx_c] <= LCD_Data;
    end
  end

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) RD_Char <= 8'h00;
    else        RD_Char <= ddram[RD_Addr];
  end

endmodule

// File: tb/tb_lcd1602_responder.sv
// Directed bench for lcd1602_responder: stimulus pushes expected reads and DDRAM writes
// into queues, monitors compare when the DUT presents RD_Char / Wr_Strobe.
module tb_lcd1602_responder;

  logic       CLK = 1'b0;
  logic       RST_n = 1'b0;
  logic       LCD_EN = 1'b0;
  logic       LCD_RS = 1'b0;
  logic       LCD_RW = 1'b0;
  logic [7:0] LCD_Data = 8'h00;
  logic [4:0] RD_Addr = 5'd0;
  logic [7:0] RD_Char;
  logic       Busy;
  logic       Disp_On;
  logic [2:0] Func_Bits;
  logic       Wr_Strobe;
  logic [4:0] Wr_Index;
  logic       Proto_Err;
  logic [7:0] Viol_Cnt;

  int checks = 0;
  int failures = 0;
  int wr_pulses = 0;

  logic [7:0] rd_q [$];
  logic [4:0] rd_aq [$];
  logic [4:0] wr_q [$];
  logic       rd_vld = 1'b0;
  logic       rd_tag = 1'b0;

  lcd1602_responder #(.BUSY_SHORT(50), .BUSY_LONG(2000)) dut (
    .CLK(CLK), .RST_n(RST_n), .LCD_EN(LCD_EN), .LCD_RS(LCD_RS), .LCD_RW(LCD_RW),
    .LCD_Data(LCD_Data), .RD_Addr(RD_Addr), .RD_Char(RD_Char), .Busy(Busy),
    .Disp_On(Disp_On), .Func_Bits(Func_Bits), .Wr_Strobe(Wr_Strobe), .Wr_Index(Wr_Index),
    .Proto_Err(Proto_Err), .Viol_Cnt(Viol_Cnt)
  );

  always #10 CLK = ~CLK;

  always @(posedge CLK) rd_tag <= rd_vld;

  // Monitor: read responses one cycle after the request, and every DDRAM write pulse.
  always @(negedge CLK) begin : monitor
    logic [7:0] e;
    logic [4:0] a;
    if (RST_n && rd_tag) begin
      checks++;
      if (rd_q.size() == 0) begin
        failures++;
        $display("FAIL rd_char unexpected response got=%h", RD_Char);
      end else begin
        e = rd_q.pop_front();
        a = rd_aq.pop_front();
        if (RD_Char !== e) begin
          failures++;
          $display("FAIL rd_char[%0d] got=%h exp=%h", a, RD_Char, e);
        end
      end
    end
    if (RST_n && Wr_Strobe) begin
      wr_pulses++;
      checks++;
      if (wr_q.size() == 0) begin
        failures++;
        $display("FAIL wr_strobe unexpected index=%0d", Wr_Index);
      end else begin
        a = wr_q.pop_front();
        if (Wr_Index !== a) begin
          failures++;
          $display("FAIL wr_index got=%0d exp=%0d", Wr_Index, a);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  task automatic rd(input logic [4:0] a, input logic [7:0] e);
    @(negedge CLK);
    RD_Addr = a;
    rd_q.push_back(e);
    rd_aq.push_back(a);
    rd_vld = 1'b1;
    @(negedge CLK);
    rd_vld = 1'b0;
  endtask

  // Issue one EN pulse; returns on the first negedge after the capturing posedge.
  task automatic start(input logic rs, input logic rw, input logic [7:0] d);
    @(negedge CLK);
    LCD_RS = rs;
    LCD_RW = rw;
    LCD_Data = d;
    LCD_EN = 1'b1;
    @(negedge CLK);
    LCD_EN = 1'b0;
    @(negedge CLK);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 5000 && Busy; i++) @(negedge CLK);
    if (Busy) begin
      checks++;
      failures++;
      $display("FAIL wait_idle timeout busy=%0b", Busy);
    end
  endtask

  task automatic send(input logic rs, input logic [7:0] d);
    start(rs, 1'b0, d);
    wait_idle();
  endtask

  task automatic wr(input logic [7:0] ch, input int idx);
    if (idx >= 0) wr_q.push_back(5'(idx));
    send(1'b1, ch);
  endtask

  initial begin : stim
    string msg;
    int    p0;
    int    n;
    msg = "F=50000000Hz";

    repeat (3) @(negedge CLK);
    check("reset_rd_char", 32'(RD_Char), 32'h00);
    check("reset_busy", 32'(Busy), 32'd0);
    check("reset_viol", 32'(Viol_Cnt), 32'd0);
    check("reset_func", 32'(Func_Bits), 32'd0);
    check("reset_disp", 32'(Disp_On), 32'd0);
    check("reset_proto", 32'(Proto_Err), 32'd0);
    RST_n = 1'b1;
    for (int i = 0; i < 32; i++) rd(5'(i), 8'h20);

    // Init sequence and the frequency string on line 1.
    send(1'b0, 8'h38);
    send(1'b0, 8'h0C);
    send(1'b0, 8'h06);
    send(1'b0, 8'h80);
    check("func_bits", 32'(Func_Bits), 32'b110);
    check("disp_on", 32'(Disp_On), 32'd1);
    p0 = wr_pulses;
    for (int i = 0; i < 12; i++) wr(msg[i], i);
    @(negedge CLK);
    check("wr_pulse_count", 32'(wr_pulses - p0), 32'd12);
    for (int i = 0; i < 12; i++) rd(5'(i), msg[i]);
    rd(5'd12, 8'h20);

    // Line 2 addressing and off-screen AC values.
    send(1'b0, 8'hC0);
    wr("A", 16);
    wr("B", 17);
    send(1'b0, 8'h8F);
    wr("X", 15);
    wr("Y", -1);
    rd(5'd15, "X");
    rd(5'd16, "A");
    rd(5'd17, "B");
    // Two left shifts from AC=0x11 land on 0x0F.
    send(1'b0, 8'h10);
    send(1'b0, 8'h10);
    wr("K", 15);
    rd(5'd15, "K");

    // 0x27 wraps to 0x40.
    send(1'b0, 8'hA7);
    wr("Z", -1);
    wr("Q", 16);
    rd(5'd16, "Q");
    rd(5'd17, "B");

    // Decrement wrap 0x00 -> 0x67, then increment wrap 0x67 -> 0x00.
    send(1'b0, 8'h04);
    send(1'b0, 8'h80);
    wr("a", 0);
    send(1'b0, 8'h06);
    wr("b", -1);
    wr("c", 0);
    rd(5'd0, "c");
    rd(5'd1, "=");

    // CGRAM mode discards data; DDRAM address command leaves it.
    send(1'b0, 8'h40);
    wr("g", -1);
    send(1'b0, 8'h81);
    wr("h", 1);
    rd(5'd1, "h");
    send(1'b0, 8'h08);
    check("disp_off", 32'(Disp_On), 32'd0);

    // Clear with a violating strobe 100 cycles into the long busy window.
    n = 0;
    start(1'b0, 1'b0, 8'h01);
    for (int i = 0; i < 5000; i++) begin
      if (Busy) n++;
      else break;
      if (i == 100) begin
        LCD_RS = 1'b1;
        LCD_Data = "W";
        LCD_EN = 1'b1;
      end
      if (i == 101) LCD_EN = 1'b0;
      @(negedge CLK);
    end
    check("clear_busy_cycles", 32'(n), 32'd2000);
    check("viol_after_clear", 32'(Viol_Cnt), 32'd1);
    for (int i = 0; i < 32; i++) rd(5'(i), 8'h20);

    // Read strobe: protocol error only, no busy, no command effect.
    start(1'b0, 1'b1, 8'h3C);
    check("proto_busy", 32'(Busy), 32'd0);
    check("proto_err", 32'(Proto_Err), 32'd1);
    check("proto_func", 32'(Func_Bits), 32'b110);

    // 300 strobes during home busy saturate the violation counter.
    start(1'b0, 1'b0, 8'h02);
    repeat (300) begin
      LCD_EN = 1'b1;
      @(negedge CLK);
      LCD_EN = 1'b0;
      @(negedge CLK);
    end
    check("viol_sat", 32'(Viol_Cnt), 32'd255);
    check("busy_during_sat", 32'(Busy), 32'd1);
    check("proto_sticky", 32'(Proto_Err), 32'd1);
    wait_idle();
    rd(5'd0, 8'h20);
    repeat (3) @(negedge CLK);
    check("wr_queue_drained", 32'(wr_q.size()), 32'd0);
    check("rd_queue_drained", 32'(rd_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
